frame_formatter: RTL

Parametrised per-channel frame formatter for the ASIC readout path. It aligns the raw sample stream with the shift-register readout strobe and counts columns per frame. Each frame is written as a header, data or footer word stream into the per-channel event buffer RAM. It generalises frame length, data width, alignment delay and event-counter width, detects a single rising edge of the strobe, and can suppress RAM writes for dummy (strobe-less) frames.

---
 rtl/frame_formatter_pkg.sv | 24 ++
 rtl/frame_formatter_delay_line.sv | 31 +++
 rtl/frame_formatter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_formatter_pkg.sv
// Shared codes for the per-channel frame formatter: event types,
// header/footer tags, fill pattern and word-select codes.
package frame_formatter_pkg;

    // Event type carried in header/footer words and used for write gating
    localparam logic [1:0] EVT_DUMMY   = 2'b00;
    localparam logic [1:0] EVT_READOUT = 2'b10;

    // Tag nibbles that open header and footer words
    localparam logic [3:0] HDR_WORD = 4'hF;
    localparam logic [3:0] FTR_WORD = 4'hE;

    // Pattern written when no word is selected
    localparam logic [15:0] FILL_WORD = 16'h00FF;

    // Word-select codes on CH_ID
    typedef enum logic [1:0] {
        CH_FILL = 2'b00,
        CH_HDR  = 2'b01,
        CH_DATA = 2'b10,
        CH_FTR  = 2'b11
    } ch_id_e;

endpackage

// File: rtl/frame_formatter_delay_line.sv
// Plain W-bit shift register of DEPTH stages used to align the sample
// stream with the column counter. All stages clear on reset.
module delay_line #(
    parameter int W     = 16,
    parameter int DEPTH = 48
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] tap_q [DEPTH];

    // Shift one stage per clock, newest sample enters at tap 0
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            tap_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    assign q_o = tap_q[DEPTH-1];

endmodule

// File: rtl/frame_formatter.sv
// Per-channel frame formatter: synchronises the readout strobe and the
// sample stream, counts columns per frame, and emits header / data /
// footer / fill words with a matching RAM address and write enable.
module frame_formatter
    import frame_formatter_pkg::*;
#(
    parameter int DW          = 16,
    parameter int NCOL        = 48,
    parameter int DELAY       = 48,
    parameter int SYNC_STAGES = 4,
    parameter int NEVT_W      = 4,
    localparam int CW         = $clog2(NCOL)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        CH_ID,
    input  logic              DUMMY_EN,
    input  logic [DW-1:0]     DATA_IN,
    input  logic              SR_OUT_IN,
    output logic [DW-1:0]     DATA_OUT,
    output logic [CW-1:0]     MEM_ADDR,
    output logic              MEM_WREN,
    output logic              FIRST_ROW_FLAG,
    output logic [NEVT_W-1:0] EVT_CNT
);

    // Width of the packed tag/type/column/event field in header words
    localparam int HW = 6 + CW + NEVT_W;

    // Builds a header or footer word, MSB-aligned, remaining LSBs zero
    function automatic logic [DW-1:0] make_word(
        input logic [3:0]        tag,
        input logic [1:0]        typ,
        input logic [CW-1:0]     col,
        input logic [NEVT_W-1:0] evt
    );
        logic [DW-1:0] w;
        w = '0;
        w[DW-1 -: HW] = {tag, typ, col, evt};
        return w;
    endfunction

    // ---------------- strobe chain ----------------
    logic [SYNC_STAGES-1:0] strb_q;
    logic                   s_prev_q;
    logic                   strobe;

    // Synchronise the strobe and reduce any high level to a single pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            strb_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            strb_q[0] <= SR_OUT_IN;
            s_prev_q  <= strb_q[0];
            strb_q[1] <= strb_q[0] & ~s_prev_q;
            for (int i = 2; i < SYNC_STAGES; i++) begin
                strb_q[i] <= strb_q[i-1];
            end
        end
    end

    assign strobe = strb_q[SYNC_STAGES-1];

    // ---------------- data chain ----------------
    logic [DW-1:0] dsync_q [SYNC_STAGES];
    logic [DW-1:0] dly_out;
    logic [DW-1:0] cap_q;

    // Sample synchroniser, same depth as the strobe chain
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dsync_q[i] <= '0;
            end
        end else begin
            dsync_q[0] <= DATA_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dsync_q[i] <= dsync_q[i-1];
            end
        end
    end

    delay_line #(
        .W     (DW),
        .DEPTH (DELAY)
    ) u_delay_line (
        .CLK (CLK),
        .RST (RST),
        .d_i (dsync_q[SYNC_STAGES-1]),
        .q_o (dly_out)
    );

    // Capture register feeding the output mux
    always_ff @(posedge CLK) begin
        if (RST) cap_q <= '0;
        else     cap_q <= dly_out;
    end

    // ---------------- column counter ----------------
    logic [CW-1:0]     cnt_q,  cnt_d;
    logic [1:0]        type_q, type_d;
    logic [NEVT_W-1:0] nevt_q, nevt_d;

    // Next-state: strobe restarts a readout frame, wrap starts a dummy one
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        type_d = type_q;
        nevt_d = nevt_q;
        if (strobe) begin
            cnt_d  = '0;
            type_d = EVT_READOUT;
            nevt_d = nevt_q + NEVT_W'(1);
        end else if (cnt_q == CW'(NCOL-1)) begin
            cnt_d  = '0;
            type_d = EVT_DUMMY;
            nevt_d = nevt_q + NEVT_W'(1);
        end
    end

    // Counter state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            type_q <= EVT_DUMMY;
            nevt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            type_q <= type_d;
            nevt_q <= nevt_d;
        end
    end

    // ---------------- header / footer words ----------------
    logic [DW-1:0] hdr_q, ftr_q;

    // Rebuilt every cycle so the column field lines up with MEM_ADDR
    always_ff @(posedge CLK) begin
        if (RST) begin
            hdr_q <= '0;
            ftr_q <= '0;
        end else begin
            hdr_q <= make_word(HDR_WORD, type_q, cnt_q, nevt_q);
            ftr_q <= make_word(FTR_WORD, type_q, cnt_q, nevt_q);
        end
    end

    // ---------------- address, type alignment, write enable ----------------
    logic [CW-1:0] addr_q, addr_p1_q, mem_addr_q;
    logic [1:0]    type_p1_q, type_p2_q;
    logic          wren_q, flag_q;

    // Address follows the column count; two extra stages match the word path
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q     <= '0;
            addr_p1_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            addr_q     <= (cnt_q == '0) ? '0 : addr_q + CW'(1);
            addr_p1_q  <= addr_q;
            mem_addr_q <= addr_p1_q;
        end
    end

    // Frame type delayed so write enable changes with the first address
    always_ff @(posedge CLK) begin
        if (RST) begin
            type_p1_q <= EVT_DUMMY;
            type_p2_q <= EVT_DUMMY;
            wren_q    <= 1'b0;
        end else begin
            type_p1_q <= type_q;
            type_p2_q <= type_p1_q;
            wren_q    <= DUMMY_EN | (type_p2_q == EVT_READOUT);
        end
    end

    // One-cycle pulse following address 2 of each frame
    always_ff @(posedge CLK) begin
        if (RST) flag_q <= 1'b0;
        else     flag_q <= (mem_addr_q == CW'(2));
    end

    // ---------------- output mux ----------------
    logic [DW-1:0] mux_d, mux_q, dout_q;

    // Word select straight from CH_ID
    always_comb begin
        mux_d = DW'(FILL_WORD);
        case (ch_id_e'(CH_ID))
            CH_HDR:  mux_d = hdr_q;
            CH_DATA: mux_d = cap_q;
            CH_FTR:  mux_d = ftr_q;
            default: mux_d = DW'(FILL_WORD);
        endcase
    end

    // Registered mux followed by the output register
    always_ff @(posedge CLK) begin
        if (RST) begin
            mux_q  <= '0;
            dout_q <= '0;
        end else begin
            mux_q  <= mux_d;
            dout_q <= mux_q;
        end
    end

    assign DATA_OUT       = dout_q;
    assign MEM_ADDR       = mem_addr_q;
    assign MEM_WREN       = wren_q;
    assign FIRST_ROW_FLAG = flag_q;
    assign EVT_CNT        = nevt_q;

endmodule
